// File: rtl/sync_handshake_bus.sv
// Single-word toggle-handshake crossing from inclk to outclk with a holding register.
// Define SYNC_HANDSHAKE_3FF_EN for 3-flop synchronisers (default is 2-flop).
module sync_handshake_bus #(
   parameter int unsigned        DATA_W    = 8,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              inclk,
   input  logic              areset,
   input  logic              outclk,
   input  logic [DATA_W-1:0] idata,
   input  logic              ivalid,
   output logic              iready,
   output logic [DATA_W-1:0] odata,
   output logic              ovalid
);

`ifdef SYNC_HANDSHAKE_3FF_EN
   localparam int unsigned SYNC_N = 3;
`else
   localparam int unsigned SYNC_N = 2;
`endif
   localparam logic [2:0] HOLD_LAST = 3'd6;

   // inclk domain
   logic                req;
   logic [DATA_W-1:0]   hold;
   logic [SYNC_N-1:0]   ack_sync;
   logic [2:0]          hold_cnt;
   logic                hold_busy;
   logic                rst_q;
   logic                accept_c;

   // outclk domain
   logic [SYNC_N-1:0]   rst_sync;
   logic                orst;
   logic [SYNC_N-1:0]   req_sync;
   logic                req_ref;
   logic                ack;

   assign accept_c = ivalid & iready;

   // Source side: accept, request toggle, ack wait and post-reset hold-off.
   always_ff @(posedge inclk) begin
      rst_q <= areset;
      if (areset) begin
         req       <= 1'b0;
         hold      <= RESET_VAL;
         ack_sync  <= '0;
         iready    <= 1'b0;
         hold_cnt  <= 3'd0;
         hold_busy <= 1'b1;
      end else begin
         ack_sync <= {ack_sync[SYNC_N-2:0], ack};
         if (hold_busy) begin
            if (hold_cnt == HOLD_LAST) begin
               hold_busy <= 1'b0;
               iready    <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 3'd1;
            end
         end else if (accept_c) begin
            req    <= ~req;
            hold   <= idata;
            iready <= 1'b0;
         end else if (!iready && (ack_sync[SYNC_N-1] == req)) begin
            iready <= 1'b1;
         end
      end
   end

   // Reset synchroniser: asserts at once so an in-flight request can never pulse ovalid.
   always_ff @(posedge outclk or posedge rst_q) begin
      if (rst_q) begin
         rst_sync <= '1;
      end else begin
         rst_sync <= {rst_sync[SYNC_N-2:0], 1'b0};
      end
   end

   assign orst = rst_sync[SYNC_N-1];

   // Destination side: detect request edge, capture word, return ack toggle.
   always_ff @(posedge outclk or posedge orst) begin
      if (orst) begin
         req_sync <= '0;
         req_ref  <= 1'b0;
         ack      <= 1'b0;
         ovalid   <= 1'b0;
         odata    <= RESET_VAL;
      end else begin
         req_sync <= {req_sync[SYNC_N-2:0], req};
         ovalid   <= 1'b0;
         if (req_sync[SYNC_N-1] != req_ref) begin
            req_ref <= req_sync[SYNC_N-1];
            ack     <= ~ack;
            ovalid  <= 1'b1;
            odata   <= hold;
         end
      end
   end

endmodule
